// File: rtl/qoa_slice_sequencer.sv
// Purpose: sequences LMS state loads and QOA slice residuals into a byte-strobed decoder and streams decoded samples.
// Latency: slice accept to first sample_valid is WAIT_CYCLES+10 cycles; each further residual adds WAIT_CYCLES+11 plus any output stall.
// Backpressure: inputs are accepted only in IDLE; sample_valid holds the sample until sample_ready. Optional macro QOA_SEQ_SAMPLE_COUNT_EN.
module qoa_slice_sequencer #(
    parameter int unsigned WAIT_CYCLES = 80
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    input  logic         lms_valid,
    output logic         lms_ready,
    input  logic [127:0] lms_data,
    input  logic         slice_valid,
    output logic         slice_ready,
    input  logic [63:0]  slice_data,
    output logic         dec_data_rdy,
    output logic [7:0]   dec_spi_in,
    input  logic [15:0]  dec_spi_out,
    output logic         sample_valid,
    input  logic         sample_ready,
    output logic [15:0]  sample_data,
    output logic         busy,
    output logic [31:0]  sample_count
);

    typedef enum logic [3:0] {
        IDLE, LMS_CMD, LMS_HI, LMS_LO, SMP_CMD, SMP_WAIT, RD_CMD, RD_HI, RD_LO, OUT
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_CYCLES);

    state_t       state;
    logic [127:0] lms_sh;     // LMS words, consumed 16 bits at a time from the bottom
    logic [2:0]   trip_idx;   // triplet index: [2] selects weights, [1:0] the tap
    logic [3:0]   sf;
    logic [59:0]  res_sh;     // residuals, current one always at [59:57]
    logic [4:0]   res_idx;
    logic [7:0]   wait_cnt;

    // Only the low byte of the readback carries data.
    logic unused_spi_hi;
    assign unused_spi_hi = ^dec_spi_out[15:8];

    assign lms_ready   = (state == IDLE);
    assign slice_ready = (state == IDLE);
    assign busy        = (state != IDLE);

    // Main sequencer; a byte strobe is only raised when the strobe was low the cycle before, which guarantees a gap.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state        <= IDLE;
            dec_data_rdy <= 1'b0;
            dec_spi_in   <= 8'h00;
            sample_valid <= 1'b0;
            sample_data  <= 16'h0000;
            lms_sh       <= '0;
            trip_idx     <= '0;
            sf           <= '0;
            res_sh       <= '0;
            res_idx      <= '0;
            wait_cnt     <= '0;
        end else begin
            dec_data_rdy <= 1'b0;
            dec_spi_in   <= 8'h00;
            case (state)
                IDLE: begin
                    if (lms_valid) begin
                        lms_sh   <= lms_data;
                        trip_idx <= '0;
                        state    <= LMS_CMD;
                    end else if (slice_valid) begin
                        sf      <= slice_data[63:60];
                        res_sh  <= slice_data[59:0];
                        res_idx <= '0;
                        state   <= SMP_CMD;
                    end
                end
                LMS_CMD: begin
                    if (!dec_data_rdy) begin
                        dec_data_rdy <= 1'b1;
                        dec_spi_in   <= {4'b0000, trip_idx[1:0], trip_idx[2], 1'b0};
                        state        <= LMS_HI;
                    end
                end
                LMS_HI: begin
                    if (!dec_data_rdy) begin
                        dec_data_rdy <= 1'b1;
                        dec_spi_in   <= lms_sh[15:8];
                        state        <= LMS_LO;
                    end
                end
                LMS_LO: begin
                    if (!dec_data_rdy) begin
                        dec_data_rdy <= 1'b1;
                        dec_spi_in   <= lms_sh[7:0];
                        lms_sh       <= lms_sh >> 16;
                        trip_idx     <= trip_idx + 3'd1;
                        state        <= (trip_idx == 3'd7) ? IDLE : LMS_CMD;
                    end
                end
                SMP_CMD: begin
                    if (!dec_data_rdy) begin
                        dec_data_rdy <= 1'b1;
                        dec_spi_in   <= {sf, res_sh[59:57], 1'b1};
                    end else begin
                        wait_cnt <= '0;
                        state    <= SMP_WAIT;
                    end
                end
                SMP_WAIT: begin
                    // First cycle here is the gap after the command strobe, then WAIT_CYCLES idle cycles.
                    if (wait_cnt == WAIT_LAST) begin
                        state <= RD_CMD;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RD_CMD: begin
                    dec_data_rdy <= 1'b1;
                    dec_spi_in   <= 8'h80;
                    state        <= RD_HI;
                end
                RD_HI: begin
                    if (!dec_data_rdy) begin
                        sample_data[15:8] <= dec_spi_out[7:0];
                        dec_data_rdy      <= 1'b1;
                        state             <= RD_LO;
                    end
                end
                RD_LO: begin
                    // Third strobe is a dummy that returns the decoder to its wait state.
                    if (!dec_data_rdy) begin
                        sample_data[7:0] <= dec_spi_out[7:0];
                        dec_data_rdy     <= 1'b1;
                        state            <= OUT;
                    end
                end
                OUT: begin
                    if (dec_data_rdy) begin
                        sample_valid <= 1'b0;
                    end else if (!sample_valid) begin
                        sample_valid <= 1'b1;
                    end else if (sample_ready) begin
                        sample_valid <= 1'b0;
                        if (res_idx == 5'd19) begin
                            state <= IDLE;
                        end else begin
                            res_idx <= res_idx + 5'd1;
                            res_sh  <= res_sh << 3;
                            state   <= SMP_CMD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef QOA_SEQ_SAMPLE_COUNT_EN
    // Free-running count of delivered samples, wraps naturally at 2^32.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sample_count <= 32'd0;
        end else if (state == OUT && sample_valid && sample_ready) begin
            sample_count <= sample_count + 32'd1;
        end
    end
`else
    assign sample_count = 32'd0;
`endif

endmodule

// File: tb/tb_qoa_slice_sequencer.sv
// Purpose: directed self-checking bench for qoa_slice_sequencer with a byte-level decoder model.
// Latency: checks the WAIT_CYCLES+10 cycle slice-to-sample latency at the default parameter.
// Backpressure: exercises sample_ready stalls, lms/slice priority and mid-slice reset.
module tb_qoa_slice_sequencer;

    logic         sys_clk = 1'b0;
    logic         sys_rst = 1'b1;
    logic         lms_valid = 1'b0;
    logic         lms_ready;
    logic [127:0] lms_data = '0;
    logic         slice_valid = 1'b0;
    logic         slice_ready;
    logic [63:0]  slice_data = '0;
    logic         dec_data_rdy;
    logic [7:0]   dec_spi_in;
    logic [15:0]  dec_spi_out = 16'h0000;
    logic         sample_valid;
    logic         sample_ready = 1'b0;
    logic [15:0]  sample_data;
    logic         busy;
    logic [31:0]  sample_count;

    int n_checks = 0;
    int n_pass   = 0;

    // Monitor / decoder model state, written only by the monitor process
    logic [7:0] byte_log[$];
    int         gap_err   = 0;
    int         bad_idle  = 0;
    int         hs_count  = 0;
    int         sample_bad = 0;
    logic       prev_rdy  = 1'b0;
    int         dec_phase = 0;
    logic [7:0] dec_hi = 8'hAB;
    logic [7:0] dec_lo = 8'hCD;

    qoa_slice_sequencer dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .lms_valid    (lms_valid),
        .lms_ready    (lms_ready),
        .lms_data     (lms_data),
        .slice_valid  (slice_valid),
        .slice_ready  (slice_ready),
        .slice_data   (slice_data),
        .dec_data_rdy (dec_data_rdy),
        .dec_spi_in   (dec_spi_in),
        .dec_spi_out  (dec_spi_out),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sample_data  (sample_data),
        .busy         (busy),
        .sample_count (sample_count)
    );

    always #5 sys_clk = ~sys_clk;

    // Byte logger, strobe-gap checker, decoder readback model and sample handshake counter
    always @(negedge sys_clk) begin
        if (sys_rst) begin
            prev_rdy  = 1'b0;
            dec_phase = 0;
        end else begin
            if (dec_data_rdy) begin
                byte_log.push_back(dec_spi_in);
                if (prev_rdy) gap_err++;
                if (dec_spi_in == 8'h80) begin
                    dec_spi_out = {8'hEE, dec_hi};
                    dec_phase   = 1;
                end else if (dec_phase == 1) begin
                    dec_spi_out = {8'hEE, dec_lo};
                    dec_phase   = 2;
                end else if (dec_phase == 2) begin
                    dec_phase = 0;
                end
            end else if (dec_spi_in !== 8'h00) begin
                bad_idle++;
            end
            prev_rdy = dec_data_rdy;
            if (sample_valid && sample_ready) begin
                hs_count++;
                if (sample_data !== {dec_hi, dec_lo}) sample_bad++;
            end
        end
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (dec_data_rdy !== 1'b0) $display("FAIL reset_dec_rdy: got %b want 0", dec_data_rdy); else n_pass++;
        n_checks++; if (sample_valid !== 1'b0) $display("FAIL reset_sample_valid: got %b want 0", sample_valid); else n_pass++;
        n_checks++; if (sample_count !== 32'd0) $display("FAIL reset_sample_count: got %0d want 0", sample_count); else n_pass++;
        sys_rst = 1'b0;
        n_checks++; if (lms_ready !== 1'b1 || slice_ready !== 1'b1)
            $display("FAIL reset_ready: got lms=%b slice=%b want 1 1", lms_ready, slice_ready); else n_pass++;
    endtask

    task automatic test_lms_load();
        int lb = byte_log.size();
        int g0 = gap_err;
        int n  = 0;
        lms_data  = 128'h1234;
        lms_valid = 1'b1;
        step();
        lms_valid = 1'b0;
        while (busy && n < 500) begin step(); n++; end
        n_checks++; if (busy) $display("FAIL lms_timeout: busy still %b after %0d cycles", busy, n); else n_pass++;
        step();
        n_checks++; if (byte_log.size() - lb !== 24) $display("FAIL lms_pulse_count: got %0d want 24", byte_log.size() - lb); else n_pass++;
        n_checks++; if (byte_log[lb] !== 8'h00 || byte_log[lb+1] !== 8'h12 || byte_log[lb+2] !== 8'h34)
            $display("FAIL lms_first_triplet: got %h %h %h want 00 12 34", byte_log[lb], byte_log[lb+1], byte_log[lb+2]); else n_pass++;
        n_checks++; if (byte_log[lb+3] !== 8'h04) $display("FAIL lms_hist1_cmd: got %h want 04", byte_log[lb+3]); else n_pass++;
        n_checks++; if (byte_log[lb+12] !== 8'h02) $display("FAIL lms_weight0_cmd: got %h want 02", byte_log[lb+12]); else n_pass++;
        n_checks++; if (byte_log[lb+21] !== 8'h0E) $display("FAIL lms_weight3_cmd: got %h want 0e", byte_log[lb+21]); else n_pass++;
        n_checks++; if (gap_err !== g0) $display("FAIL lms_gap: got %0d back-to-back strobes want 0", gap_err - g0); else n_pass++;
    endtask

    task automatic test_slice();
        int lb = byte_log.size();
        int n  = 0;
        int ncmd = 0;
        int hb = hs_count;
        int sb = sample_bad;
        int stalled_bad = 0;
        int lsz;
        dec_hi = 8'hAB;
        dec_lo = 8'hCD;
        sample_ready = 1'b0;
        slice_data  = 64'h123456789ABCDEF0;
        slice_valid = 1'b1;
        step();
        slice_valid = 1'b0;
        slice_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        while (!sample_valid && n < 200) begin step(); n++; end
        n_checks++; if (n !== 90) $display("FAIL slice_latency: got %0d cycles want 90", n); else n_pass++;
        n_checks++; if (sample_data !== 16'hABCD) $display("FAIL slice_sample_data: got %h want abcd", sample_data); else n_pass++;
        lsz = byte_log.size();
        for (int i = 0; i < 10; i++) begin
            step();
            if (sample_valid !== 1'b1 || sample_data !== 16'hABCD) stalled_bad++;
        end
        n_checks++; if (stalled_bad !== 0) $display("FAIL stall_hold: got %0d unstable cycles want 0", stalled_bad); else n_pass++;
        n_checks++; if (byte_log.size() !== lsz) $display("FAIL stall_no_strobe: got %0d strobes want 0", byte_log.size() - lsz); else n_pass++;
        sample_ready = 1'b1;
        n = 0;
        while (busy && n < 3000) begin step(); n++; end
        n_checks++; if (busy) $display("FAIL slice_timeout: busy still %b after %0d cycles", busy, n); else n_pass++;
        step();
        for (int i = lb; i < byte_log.size(); i++) if (byte_log[i][0]) ncmd++;
        n_checks++; if (byte_log[lb] !== 8'h13 || byte_log[lb+4] !== 8'h11)
            $display("FAIL slice_first_cmds: got %h %h want 13 11", byte_log[lb], byte_log[lb+4]); else n_pass++;
        n_checks++; if (ncmd !== 20) $display("FAIL slice_cmd_count: got %0d want 20", ncmd); else n_pass++;
        n_checks++; if (byte_log.size() - lb !== 80) $display("FAIL slice_byte_count: got %0d want 80", byte_log.size() - lb); else n_pass++;
        n_checks++; if (hs_count - hb !== 20 || sample_bad !== sb)
            $display("FAIL slice_samples: got %0d handshakes %0d bad want 20 0", hs_count - hb, sample_bad - sb); else n_pass++;
        n_checks++; if (bad_idle !== 0) $display("FAIL idle_byte_zero: got %0d nonzero idle bytes want 0", bad_idle); else n_pass++;
    endtask

    task automatic test_priority_reset();
        int lb = byte_log.size();
        int hb = hs_count;
        int n  = 0;
        bit seen_idle = 0;
        int lsz;
        sample_ready = 1'b1;
        lms_data    = 128'h5566;
        slice_data  = 64'h123456789ABCDEF0;
        lms_valid   = 1'b1;
        slice_valid = 1'b1;
        step();
        lms_valid = 1'b0;
        while (n < 500) begin
            step(); n++;
            if (!busy) seen_idle = 1;
            else if (seen_idle) break;
        end
        slice_valid = 1'b0;
        n_checks++; if (!(seen_idle && busy)) $display("FAIL prio_slice_accept: got idle=%0d busy=%b want 1 1", seen_idle, busy); else n_pass++;
        n = 0;
        while (hs_count - hb < 7 && n < 2000) begin step(); n++; end
        sample_ready = 1'b0;
        n = 0;
        while (!sample_valid && n < 200) begin step(); n++; end
        n_checks++; if (byte_log[lb] !== 8'h00 || byte_log[lb+1] !== 8'h55 || byte_log[lb+24] !== 8'h13)
            $display("FAIL prio_order: got %h %h %h want 00 55 13", byte_log[lb], byte_log[lb+1], byte_log[lb+24]); else n_pass++;
        n_checks++; if (sample_valid !== 1'b1 || hs_count - hb !== 7)
            $display("FAIL prio_at_res7: got valid=%b hs=%0d want 1 7", sample_valid, hs_count - hb); else n_pass++;
        sys_rst = 1'b1;
        #2;
        n_checks++; if (sample_valid !== 1'b0 || sample_data !== 16'h0000)
            $display("FAIL async_clear_sample: got valid=%b data=%h want 0 0000", sample_valid, sample_data); else n_pass++;
        n_checks++; if (busy !== 1'b0 || dec_data_rdy !== 1'b0 || dec_spi_in !== 8'h00)
            $display("FAIL async_clear_ctrl: got busy=%b rdy=%b byte=%h want 0 0 00", busy, dec_data_rdy, dec_spi_in); else n_pass++;
        step();
        sys_rst = 1'b0;
        n_checks++; if (slice_ready !== 1'b1) $display("FAIL post_reset_ready: got %b want 1", slice_ready); else n_pass++;
        lsz = byte_log.size();
        repeat (20) step();
        n_checks++; if (busy !== 1'b0 || byte_log.size() !== lsz)
            $display("FAIL post_reset_discard: got busy=%b strobes=%0d want 0 0", busy, byte_log.size() - lsz); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int hb = hs_count;
        int sb = sample_bad;
        int n;
        logic [31:0] exp_cnt;
`ifdef QOA_SEQ_SAMPLE_COUNT_EN
        exp_cnt = 32'd40;
`else
        exp_cnt = 32'd0;
`endif
        dec_hi = 8'h5A;
        dec_lo = 8'hC3;
        sample_ready = 1'b1;
        for (int s = 0; s < 2; s++) begin
            slice_data  = (s == 0) ? 64'hFEDCBA9876543210 : 64'h0F0F0F0F0F0F0F0F;
            slice_valid = 1'b1;
            step();
            slice_valid = 1'b0;
            n = 0;
            while (busy && n < 3000) begin step(); n++; end
            n_checks++; if (busy) $display("FAIL b2b_timeout: slice %0d busy still %b", s, busy); else n_pass++;
        end
        step();
        n_checks++; if (hs_count - hb !== 40 || sample_bad !== sb)
            $display("FAIL b2b_samples: got %0d handshakes %0d bad want 40 0", hs_count - hb, sample_bad - sb); else n_pass++;
        n_checks++; if (sample_count !== exp_cnt) $display("FAIL sample_count: got %0d want %0d", sample_count, exp_cnt); else n_pass++;
        n_checks++; if (gap_err !== 0) $display("FAIL strobe_gap_total: got %0d want 0", gap_err); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_lms_load();
        test_slice();
        test_priority_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
